// File: rtl/mips32_mem_pkg.sv
// Shared types for the MIPS32 memory responder.
// State encoding, port IDs and the latched request bundle.
package mips32_mem_pkg;

  localparam int DEPTH_DEF = 1024;
  localparam int AW_DEF    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } port_t;

  typedef struct packed {
    port_t       port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mips32_rr_arbiter.sv
// Two-way round-robin arbiter for the fetch and data ports.
// grant[0]=INSTR, grant[1]=DATA; last_grant moves on acceptance.
import mips32_mem_pkg::*;

module mips32_rr_arbiter (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       take,
  output logic [1:0] grant
);

  port_t last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (req_i & req_d):
        grant = (last_grant == INSTR) ? 2'b10 : 2'b01;
      (req_d & ~req_i):
        grant = 2'b10;
      (req_i & ~req_d):
        grant = 2'b01;
      default:
        grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      last_grant <= INSTR;
    end else if (take) begin
      last_grant <= grant[1] ? DATA : INSTR;
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory serving fetch and data ports through one
// access engine with wait states and round-robin arbitration.
import mips32_mem_pkg::*;

module mips32_mem_responder #(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int AW          = AW_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  input  logic        d_rsp_ready,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] Mem [0:DEPTH-1];

  state_t      state, state_nxt;
  mem_req_t    req;
  logic [3:0]  cnt;
  logic        rsp_vld;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [1:0]  grant;
  logic        acc_i, acc_d, accept;
  logic        access, oor, rsp_take;
  logic [AW-1:0] idx;

  mips32_rr_arbiter u_arb (
    .clk1  (clk1),
    .rst_n (rst_n),
    .req_i (i_req_valid),
    .req_d (d_req_valid),
    .take  (accept),
    .grant (grant)
  );

  assign acc_i    = i_req_valid & i_req_ready;
  assign acc_d    = d_req_valid & d_req_ready;
  assign accept   = acc_i | acc_d;
  assign idx      = req.addr[AW-1:0];
  assign oor      = |req.addr[31:AW];
  assign access   = (state == BUSY) && (cnt == 4'd0);
  assign rsp_take = (req.port == DATA) ? d_rsp_ready
                                       : i_rsp_ready;

  always_ff @(posedge clk1) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = BUSY;
      BUSY:    if (access)   state_nxt = RESP;
      RESP:    if (rsp_take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      req      <= '0;
      cnt      <= '0;
      rsp_vld  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      if (accept) begin
        req.port  <= acc_d ? DATA : INSTR;
        req.we    <= acc_d & d_req_we;
        req.addr  <= acc_d ? d_req_addr : i_req_addr;
        req.wdata <= acc_d ? d_req_wdata : '0;
        cnt       <= WAIT_INIT;
      end
      if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (access) begin
        rsp_vld  <= 1'b1;
        rsp_err  <= oor;
        rsp_data <= (oor || req.we) ? '0 : Mem[idx];
      end else if (state == RESP && rsp_take) begin
        rsp_vld  <= 1'b0;
        rsp_err  <= 1'b0;
        rsp_data <= '0;
      end
    end
  end

  // Stores are gated by reset so a store on its access edge is dropped.
  always_ff @(posedge clk1) begin
    if (rst_n && access && req.we && !oor && req.port == DATA)
      Mem[idx] <= req.wdata;
  end

  always_comb begin
    i_req_ready = (state == IDLE) & grant[0];
    d_req_ready = (state == IDLE) & grant[1];
    i_rsp_valid = rsp_vld & (req.port == INSTR);
    d_rsp_valid = rsp_vld & (req.port == DATA);
    i_rsp_err   = rsp_err & (req.port == INSTR);
    d_rsp_err   = rsp_err & (req.port == DATA);
    i_rsp_data  = (req.port == INSTR) ? rsp_data : '0;
    d_rsp_rdata = (req.port == DATA)  ? rsp_data : '0;
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Bench for mips32_mem_responder: vector table, scoreboard queue,
// and sequences for arbitration, backpressure and mid-access reset.
import mips32_mem_pkg::*;

module tb_mips32_mem_responder;

  localparam int WAIT = 1;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid, i_rsp_ready;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_ready;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;

  always #5 clk1 = ~clk1;

  mips32_mem_responder #(.WAIT_CYCLES(WAIT)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_rsp_valid (i_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .i_rsp_data  (i_rsp_data),
    .i_rsp_err   (i_rsp_err),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_rsp_valid (d_rsp_valid),
    .d_rsp_ready (d_rsp_ready),
    .d_rsp_rdata (d_rsp_rdata),
    .d_rsp_err   (d_rsp_err)
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic pop_chk(input logic port, input logic [31:0] data,
                         input logic err, input logic other);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty got port=%0d want=none", port);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", 32'(port), 32'(e.port));
      chk("rsp_data", data, e.data);
      chk("rsp_err", 32'(err), 32'(e.err));
      chk("other_port_quiet", 32'(other), 32'd0);
    end
  endtask

  always @(negedge clk1) begin
    if (rst_n) begin
      if (i_rsp_valid && i_rsp_ready)
        pop_chk(1'b0, i_rsp_data, i_rsp_err,
                d_rsp_valid | d_rsp_err | (|d_rsp_rdata));
      if (d_rsp_valid && d_rsp_ready)
        pop_chk(1'b1, d_rsp_rdata, d_rsp_err,
                i_rsp_valid | i_rsp_err | (|i_rsp_data));
    end
  end

  task automatic do_req(input vec_t v);
    bit got;
    int k;
    @(posedge clk1); #1;
    if (v.port) begin
      d_req_valid = 1'b1;
      d_req_we    = v.we;
      d_req_addr  = v.addr;
      d_req_wdata = v.wdata;
    end else begin
      i_req_valid = 1'b1;
      i_req_addr  = v.addr;
    end
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk1);
      if (v.port ? d_req_ready : i_req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("req_timeout", 32'd0, 32'd1);
      i_req_valid = 1'b0;
      d_req_valid = 1'b0;
      return;
    end
    sb.push_back('{v.port, v.exp_d, v.exp_e});
    @(posedge clk1); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    // Scramble request fields; they must be ignored while busy.
    i_req_addr  = 32'hffff_fff0;
    d_req_addr  = 32'h0000_0003;
    d_req_wdata = 32'hdead_beef;
    d_req_we    = 1'b1;
    k = 1;
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk1);
      if (v.port ? d_rsp_valid : i_rsp_valid) begin
        got = 1;
        break;
      end
      @(posedge clk1);
      k++;
    end
    if (!got) chk("rsp_timeout", 32'd0, 32'd1);
    else      chk("rsp_latency", 32'(k), 32'(WAIT + 2));
  endtask

  bit          got, stable, both;
  int          n;
  logic [3:0]  order;
  logic [31:0] cap;

  initial begin
    rst_n       = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_rsp_ready = 1'b1;
    d_req_valid = 1'b0;
    d_req_we    = 1'b0;
    d_req_addr  = '0;
    d_req_wdata = '0;
    d_rsp_ready = 1'b1;

    dut.Mem[0]    = 32'h2801000a;
    dut.Mem[1]    = 32'h3c011234;
    dut.Mem[7]    = 32'h00000011;
    dut.Mem[1023] = 32'haabbccdd;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h0, 32'h2801000a, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'h5,        32'h1e, 32'h0,       1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h5,        32'h0, 32'h1e,       1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h400,      32'h77, 32'h0,       1'b1};
    vecs[4]  = '{1'b1, 1'b0, 32'h400,      32'h0, 32'h0,        1'b1};
    vecs[5]  = '{1'b0, 1'b0, 32'h400,      32'h0, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 1'b0, 32'h1,        32'h0, 32'h3c011234, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h3ff,      32'h0, 32'haabbccdd, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h3ff,      32'h55, 32'h0,       1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h3ff,      32'h0, 32'h55,       1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'hffffffff, 32'h0, 32'h0,        1'b1};

    repeat (2) @(posedge clk1);
    #1 rst_n = 1'b1;
    @(negedge clk1);
    chk("reset_outs",
        {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
         i_rsp_err, d_rsp_err}, 32'd0);
    chk("reset_idata", i_rsp_data, 32'd0);
    chk("reset_drdata", d_rsp_rdata, 32'd0);

    foreach (vecs[i]) do_req(vecs[i]);
    @(posedge clk1);
    chk("oor_store_no_alias", dut.Mem[0], 32'h2801000a);
    chk("mem5_stored", dut.Mem[5], 32'h0000001e);

    // Reset lands on the access edge of a store to addr 7.
    @(posedge clk1); #1;
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 32'h7;
    d_req_wdata = 32'h0000bad0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk1);
      if (d_req_ready) begin
        got = 1;
        break;
      end
    end
    chk("rst_store_accept", 32'(got), 32'd1);
    @(posedge clk1); #1 d_req_valid = 1'b0;
    @(posedge clk1); #1 rst_n = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    chk("midrst_outs",
        {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid,
         i_rsp_err, d_rsp_err}, 32'd0);
    chk("midrst_drdata", d_rsp_rdata, 32'd0);
    chk("midrst_mem7", dut.Mem[7], 32'h00000011);
    chk("midrst_last_grant", 32'(dut.u_arb.last_grant), 32'(INSTR));
    @(posedge clk1); #1 rst_n = 1'b1;

    // Both ports valid continuously: expect D,I,D,I.
    i_req_addr  = 32'h0;
    d_req_addr  = 32'h5;
    d_req_we    = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    n = 0;
    order = '0;
    both = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk1);
      if (i_req_ready && d_req_ready) both = 1;
      if (d_req_ready) begin
        sb.push_back('{1'b1, 32'h1e, 1'b0});
        order[n] = 1'b1;
        n++;
      end else if (i_req_ready) begin
        sb.push_back('{1'b0, 32'h2801000a, 1'b0});
        n++;
      end
    end
    @(posedge clk1); #1;
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    chk("rr_grants", 32'(n), 32'd4);
    chk("rr_order", 32'(order), 32'h5);
    chk("rr_never_both", 32'(both), 32'd0);
    for (int c = 0; c < 30 && sb.size() != 0; c++) @(posedge clk1);
    @(negedge clk1);

    // Backpressure on the data response.
    d_rsp_ready = 1'b0;
    @(posedge clk1); #1;
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = 32'h5;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk1);
      if (d_req_ready) begin
        got = 1;
        break;
      end
    end
    chk("bp_accept", 32'(got), 32'd1);
    sb.push_back('{1'b1, 32'h1e, 1'b0});
    @(posedge clk1); #1;
    d_req_valid = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk1);
      if (d_rsp_valid) begin
        got = 1;
        break;
      end
    end
    chk("bp_rsp_seen", 32'(got), 32'd1);
    cap = d_rsp_rdata;
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk1);
      @(negedge clk1);
      if (!d_rsp_valid || d_rsp_rdata !== cap || i_req_ready)
        stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_data", cap, 32'h1e);
    @(posedge clk1); #1;
    i_req_valid = 1'b0;
    d_rsp_ready = 1'b1;
    @(posedge clk1);
    @(negedge clk1);
    chk("bp_released", 32'(d_rsp_valid), 32'd0);
    chk("bp_idle", 32'(dut.state), 32'(IDLE));

    repeat (3) @(posedge clk1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips32_mem_responder.md
Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 core's memory accesses: a word-addressed 1024x32 memory serving an instruction-fetch port (read-only) and a data port (LW/SW).
- Each port uses a valid/ready request channel and a valid/ready response channel.
- The two ports are serialized through one access engine, with programmable wait states and round-robin arbitration.
- Sits between the pipeline's IF/MEM stages and the storage array, replacing direct combinational array indexing.

Parameters:
- DEPTH, 1024, number of 32-bit words
- AW, 10, index width; must equal log2(DEPTH)
- WAIT_CYCLES, 1, extra busy cycles per access (0..15)

Ports:
- clk1  in  1  single system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- i_req_valid  in  1  fetch request valid
- i_req_ready  out  1  fetch request accepted this cycle
- i_req_addr  in  32  fetch word address (PC)
- i_rsp_valid  out  1  fetch response valid
- i_rsp_ready  in  1  fetch response consumed
- i_rsp_data  out  32  instruction word
- i_rsp_err  out  1  address out of range
- d_req_valid  in  1  data request valid
- d_req_ready  out  1  data request accepted
- d_req_we  in  1  1=store (SW), 0=load (LW)
- d_req_addr  in  32  data word address (ALUOut)
- d_req_wdata  in  32  store data (B)
- d_rsp_valid  out  1  data response valid (loads and stores)
- d_rsp_ready  in  1  data response consumed
- d_rsp_rdata  out  32  load data; 0 for stores
- d_rsp_err  out  1  address out of range

Behaviour:
- Clock and reset: one clock (clk1); reset is synchronous and active-low (rst_n).
- Reset values: all outputs 0; state IDLE; last_grant = INSTR; wait counter 0. Memory contents are not reset.
- Storage: the array Mem[0:DEPTH-1] is hierarchically visible so a bench can preload it.
- FSM states: IDLE, BUSY, RESP.
- IDLE arbitration:
  - Only d valid: d wins.
  - Only i valid: i wins.
  - Both valid: grant the port not in last_grant (round-robin).
  - Ready is combinational: i_req_ready = IDLE & winner==INSTR; d_req_ready = IDLE & winner==DATA. Never both high.
- Acceptance (valid & ready at edge E0): latch port, we, addr, wdata; last_grant <= port; counter <= WAIT_CYCLES; go to BUSY.
- BUSY:
  - Counter nonzero: decrement.
  - Counter zero: perform the access at this edge and go to RESP.
  - Access edge is E0+WAIT_CYCLES+1; rsp_valid rises on the same edge.
- Access rules:
  - Range check: addr[31:AW] != 0 -> err=1, read data 0, store suppressed.
  - Otherwise a load returns Mem[addr[AW-1:0]], and a store writes Mem and returns rdata 0.
  - Fetch port never writes.
- RESP: the selected port's rsp_valid, data and err are held stable until rsp_ready. On the valid & ready edge: rsp_valid <= 0 and go to IDLE. No new request is accepted in the same cycle, so minimum turnaround is WAIT_CYCLES+3 cycles per transaction.
- Response data: the non-selected port's rsp outputs stay 0.
- Ordering: strictly one transaction in flight. A store followed by a load to the same address returns the stored value.
- Request signals are sampled only at acceptance; changes while busy are ignored.
- Reset mid-operation: an in-progress store whose access edge coincides with rst_n=0 is dropped. Pending responses are discarded and the FSM returns to IDLE.

Decomposition:
- Shared package mips32_mem_pkg: state encoding (IDLE/BUSY/RESP), port IDs (INSTR/DATA), DEPTH/AW defaults.
- One natural sub-module, mips32_rr_arbiter: 2-way round-robin with last_grant register, outputs grant one-hot.
- Storage array and FSM stay in the top.

Test Plan:
- Preload Mem[0]=32'h2801000a; fetch addr 0, rsp_ready=1, WAIT_CYCLES=1 -> i_rsp_valid rises 2 edges after accept, data 32'h2801000a, err 0.
- Store addr 5 data 32'h0000001e, then load addr 5 -> d_rsp_rdata=32'h0000001e. The store response carries rdata 0 and err 0.
- i and d both valid continuously after reset -> grants alternate D,I,D,I; a request never waits more than one transaction.
- Store to addr 32'h00000400 -> d_rsp_err=1 and Mem unchanged. Load from 32'h00000400 -> rdata 0, err 1.
- Hold d_rsp_ready=0 for 5 cycles -> d_rsp_valid and data stay stable, i_req_ready stays 0. Release -> one handshake, then IDLE.
- Assert rst_n=0 during BUSY of a store to addr 7 (Mem[7]=32'h11) -> all outputs 0 next edge, Mem[7] still 32'h11, last_grant=INSTR.
